// File: rtl/block_matmul_sequencer_pkg.sv
// Shared FSM encodings, loop-counter sizing and fetch/write sequencing constants
// for the 2x2 block matmul sequencer.
package block_matmul_sequencer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam int unsigned IDX_W      = 4;
  localparam int unsigned FETCH_LAST = 8;  // capture cycle of B11
  localparam int unsigned WRITE_LAST = 3;  // C11

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Element address generator: A/B read and C write addresses for one 2x2 block,
// computed from the next loop indices and registered when the strobe is issued.
module matmul_addr_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned N_BLK  = 2,
  parameter int unsigned K_BLK  = 2,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 64,
  parameter int unsigned C_BASE = 128,
  parameter int unsigned MI_W   = 1,
  parameter int unsigned NI_W   = 1,
  parameter int unsigned KI_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MI_W-1:0]   mi,
  input  logic [NI_W-1:0]   ni,
  input  logic [KI_W-1:0]   ki,
  input  logic [2:0]        idx,
  input  logic              rd_upd,
  input  logic              wr_upd,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  logic [31:0]       elem_r;
  logic [31:0]       elem_c;
  logic [ADDR_W-1:0] a_addr_c;
  logic [ADDR_W-1:0] b_addr_c;
  logic [ADDR_W-1:0] c_addr_c;

  // idx[2] selects B over A; idx[1:0] is the row-major position inside the block.
  assign elem_r   = 32'(idx[1]);
  assign elem_c   = 32'(idx[0]);
  assign a_addr_c = ADDR_W'(A_BASE + (2 * 32'(mi) + elem_r) * (2 * K_BLK) + 2 * 32'(ki) + elem_c);
  assign b_addr_c = ADDR_W'(B_BASE + (2 * 32'(ki) + elem_r) * (2 * N_BLK) + 2 * 32'(ni) + elem_c);
  assign c_addr_c = ADDR_W'(C_BASE + (2 * 32'(mi) + elem_r) * (2 * N_BLK) + 2 * 32'(ni) + elem_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
      wr_addr <= '0;
    end else begin
      if (rd_upd) rd_addr <= idx[2] ? b_addr_c : a_addr_c;
      if (wr_upd) wr_addr <= c_addr_c;
    end
  end

endmodule

// File: rtl/block_matmul_sequencer.sv
// Tiles C = A*B into 2x2 blocks for the systolic array: fetch, load, run,
// accumulate across K, then write each finished C tile back to memory.
module block_matmul_sequencer
  import block_matmul_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned M_BLK   = 2,
  parameter int unsigned N_BLK   = 2,
  parameter int unsigned K_BLK   = 2,
  parameter int unsigned A_BASE  = 0,
  parameter int unsigned B_BASE  = 64,
  parameter int unsigned C_BASE  = 128,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] sa_block_a1,
  output logic [DATA_W-1:0] sa_block_a2,
  output logic [DATA_W-1:0] sa_block_a3,
  output logic [DATA_W-1:0] sa_block_a4,
  output logic [DATA_W-1:0] sa_block_b1,
  output logic [DATA_W-1:0] sa_block_b2,
  output logic [DATA_W-1:0] sa_block_b3,
  output logic [DATA_W-1:0] sa_block_b4,
  output logic              sa_load,
  output logic              sa_start,
  input  logic [DATA_W-1:0] sa_result1,
  input  logic [DATA_W-1:0] sa_result2,
  input  logic [DATA_W-1:0] sa_result3,
  input  logic [DATA_W-1:0] sa_result4,
  input  logic              sa_done
);

  localparam int unsigned MI_W = idx_width(M_BLK);
  localparam int unsigned NI_W = idx_width(N_BLK);
  localparam int unsigned KI_W = idx_width(K_BLK);
  localparam int unsigned TM_W = idx_width(TIMEOUT + 1);

  logic [2:0]        state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [MI_W-1:0]   mi, mi_d;
  logic [NI_W-1:0]   ni, ni_d;
  logic [KI_W-1:0]   ki, ki_d;
  logic [TM_W-1:0]   timer, timer_d;
  logic [DATA_W-1:0] blk_a [4];
  logic [DATA_W-1:0] blk_a_d [4];
  logic [DATA_W-1:0] blk_b [4];
  logic [DATA_W-1:0] blk_b_d [4];
  logic [DATA_W-1:0] acc [4];
  logic [DATA_W-1:0] acc_d [4];
  logic [DATA_W-1:0] res [4];
  logic [DATA_W-1:0] res_d [4];
  logic              busy_d, done_d, error_d, rd_en_d, wr_en_d, sa_load_d, sa_start_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [2:0]        fetch_e;
  logic              last_tile;

  // rd_data in fetch cycle idx belongs to the word requested in cycle idx-1.
  assign fetch_e   = 3'(idx - IDX_W'(1));
  assign last_tile = (mi == MI_W'(M_BLK - 1)) && (ni == NI_W'(N_BLK - 1));

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    mi_d       = mi;
    ni_d       = ni;
    ki_d       = ki;
    timer_d    = timer;
    blk_a_d    = blk_a;
    blk_b_d    = blk_b;
    acc_d      = acc;
    res_d      = res;
    busy_d     = busy;
    done_d     = 1'b0;
    error_d    = 1'b0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data;
    sa_load_d  = 1'b0;
    sa_start_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          idx_d   = '0;
          mi_d    = '0;
          ni_d    = '0;
          ki_d    = '0;
          rd_en_d = 1'b1;
          for (int i = 0; i < 4; i++) acc_d[i] = '0;
        end
      end
      S_FETCH: begin
        if (idx != '0) begin
          if (fetch_e[2]) blk_b_d[fetch_e[1:0]] = rd_data;
          else            blk_a_d[fetch_e[1:0]] = rd_data;
        end
        if (idx == IDX_W'(FETCH_LAST)) begin
          state_d   = S_LOAD;
          sa_load_d = 1'b1;
        end else begin
          idx_d   = idx + IDX_W'(1);
          rd_en_d = (idx_d != IDX_W'(FETCH_LAST));
        end
      end
      S_LOAD: begin
        state_d    = S_RUN;
        sa_start_d = 1'b1;
        timer_d    = TM_W'(1);
      end
      S_RUN: begin
        if (sa_done) begin
          res_d   = '{sa_result1, sa_result2, sa_result3, sa_result4};
          state_d = S_ACC;
        end else if (timer >= TM_W'(TIMEOUT)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d    = timer + TM_W'(1);
          sa_start_d = 1'b1;
        end
      end
      S_ACC: begin
        for (int i = 0; i < 4; i++) acc_d[i] = acc[i] + res[i];
        idx_d = '0;
        if (ki != KI_W'(K_BLK - 1)) begin
          ki_d    = ki + KI_W'(1);
          rd_en_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = acc_d[0];
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx != IDX_W'(WRITE_LAST)) begin
          idx_d     = idx + IDX_W'(1);
          wr_en_d   = 1'b1;
          wr_data_d = acc[idx_d[1:0]];
        end else begin
          idx_d = '0;
          ki_d  = '0;
          for (int i = 0; i < 4; i++) acc_d[i] = '0;
          if (last_tile) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            if (ni == NI_W'(N_BLK - 1)) begin
              ni_d = '0;
              mi_d = mi + MI_W'(1);
            end else begin
              ni_d = ni + NI_W'(1);
            end
            rd_en_d = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      mi       <= '0;
      ni       <= '0;
      ki       <= '0;
      timer    <= '0;
      for (int i = 0; i < 4; i++) begin
        blk_a[i] <= '0;
        blk_b[i] <= '0;
        acc[i]   <= '0;
        res[i]   <= '0;
      end
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      sa_load  <= 1'b0;
      sa_start <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      mi       <= mi_d;
      ni       <= ni_d;
      ki       <= ki_d;
      timer    <= timer_d;
      blk_a    <= blk_a_d;
      blk_b    <= blk_b_d;
      acc      <= acc_d;
      res      <= res_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      rd_en    <= rd_en_d;
      wr_en    <= wr_en_d;
      wr_data  <= wr_data_d;
      sa_load  <= sa_load_d;
      sa_start <= sa_start_d;
    end
  end

  assign sa_block_a1 = blk_a[0];
  assign sa_block_a2 = blk_a[1];
  assign sa_block_a3 = blk_a[2];
  assign sa_block_a4 = blk_a[3];
  assign sa_block_b1 = blk_b[0];
  assign sa_block_b2 = blk_b[1];
  assign sa_block_b3 = blk_b[2];
  assign sa_block_b4 = blk_b[3];

  matmul_addr_gen #(
    .ADDR_W (ADDR_W),
    .N_BLK  (N_BLK),
    .K_BLK  (K_BLK),
    .A_BASE (A_BASE),
    .B_BASE (B_BASE),
    .C_BASE (C_BASE),
    .MI_W   (MI_W),
    .NI_W   (NI_W),
    .KI_W   (KI_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .mi      (mi_d),
    .ni      (ni_d),
    .ki      (ki_d),
    .idx     (idx_d[2:0]),
    .rd_upd  (rd_en_d),
    .wr_upd  (wr_en_d),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr)
  );

endmodule

// File: tb/tb_block_matmul_sequencer.sv
// Self-checking bench: sync-read memory, behavioural 2x2 array (done 6 cycles
// into start) and a full 4x4 matrix-product reference for the default 2x2x2 tiling.
module tb_block_matmul_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int AB = 0;
  localparam int BB = 64;
  localparam int CB = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic          busy, done, error, rd_en, wr_en, sa_load, sa_start;
  logic          sa_done = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] sa_block_a1, sa_block_a2, sa_block_a3, sa_block_a4;
  logic [DW-1:0] sa_block_b1, sa_block_b2, sa_block_b3, sa_block_b4;
  logic [DW-1:0] sa_result1, sa_result2, sa_result3, sa_result4;

  always #5 clk = ~clk;

  block_matmul_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sa_block_a1(sa_block_a1), .sa_block_a2(sa_block_a2),
    .sa_block_a3(sa_block_a3), .sa_block_a4(sa_block_a4),
    .sa_block_b1(sa_block_b1), .sa_block_b2(sa_block_b2),
    .sa_block_b3(sa_block_b3), .sa_block_b4(sa_block_b4),
    .sa_load(sa_load), .sa_start(sa_start),
    .sa_result1(sa_result1), .sa_result2(sa_result2),
    .sa_result3(sa_result3), .sa_result4(sa_result4),
    .sa_done(sa_done)
  );

  int errors = 0;
  int checks = 0;

  // Source matrices (written by tasks) and write capture (written by the memory model).
  logic [DW-1:0] am [4][4];
  logic [DW-1:0] bm [4][4];
  logic [DW-1:0] mem [256];
  logic [DW-1:0] cmem [256];
  int            cstamp [256];
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      cmem[wr_addr]   <= wr_data;
      cstamp[wr_addr] <= cyc;
    end
  end

  // Behavioural array: latch block on load, raise done for one cycle 6 cycles into start.
  logic [DW-1:0] ma [4];
  logic [DW-1:0] mb [4];
  int            run_cnt = 0;
  logic          hang = 1'b0;

  always @(posedge clk) begin
    if (sa_load) begin
      ma[0] <= sa_block_a1; ma[1] <= sa_block_a2; ma[2] <= sa_block_a3; ma[3] <= sa_block_a4;
      mb[0] <= sa_block_b1; mb[1] <= sa_block_b2; mb[2] <= sa_block_b3; mb[3] <= sa_block_b4;
    end
    if (sa_start) begin
      run_cnt <= run_cnt + 1;
      sa_done <= !hang && (run_cnt == 4);
    end else begin
      run_cnt <= 0;
      sa_done <= 1'b0;
    end
  end

  assign sa_result1 = 16'(32'(ma[0]) * 32'(mb[0]) + 32'(ma[1]) * 32'(mb[2]));
  assign sa_result2 = 16'(32'(ma[0]) * 32'(mb[1]) + 32'(ma[1]) * 32'(mb[3]));
  assign sa_result3 = 16'(32'(ma[2]) * 32'(mb[0]) + 32'(ma[3]) * 32'(mb[2]));
  assign sa_result4 = 16'(32'(ma[2]) * 32'(mb[1]) + 32'(ma[3]) * 32'(mb[3]));

  // Event counters sampled over each completed cycle.
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0, rd_cnt = 0, load_cnt = 0, start_cnt = 0, clash_cnt = 0;

  always @(posedge clk) begin
    if (done)     done_cnt  <= done_cnt + 1;
    if (error)    err_cnt   <= err_cnt + 1;
    if (wr_en)    wr_cnt    <= wr_cnt + 1;
    if (rd_en)    rd_cnt    <= rd_cnt + 1;
    if (sa_load)  load_cnt  <= load_cnt + 1;
    if (sa_start) start_cnt <= start_cnt + 1;
    if ((rd_en && wr_en) || (sa_load && sa_start)) clash_cnt <= clash_cnt + 1;
  end

  function automatic logic [DW-1:0] exp_c(input int r, input int c);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'(am[r][k]) * longint'(bm[k][c]);
    return 16'(s);
  endfunction

  task automatic clear_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = '0;
        bm[r][c] = '0;
      end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = 16'($urandom);
        bm[r][c] = 16'($urandom);
      end
  endtask

  task automatic put_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem[AB + r * 4 + c] = am[r][c];
        mem[BB + r * 4 + c] = bm[r][c];
      end
  endtask

  // One whole multiply from go to done, with optional extra go pulses while busy.
  task automatic run_and_check(input string name, input bit extra_go);
    int d0, e0, w0, r0, l0, k0, t0, n;
    logic [DW-1:0] e;
    put_mats();
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt; l0 = load_cnt; k0 = clash_cnt; t0 = cyc;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_go got %b want 1", name, busy); end
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      go = (extra_go && (n % 13 == 0));
    end
    go = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done_seen got %b after %0d cycles want 1", name, done, n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt - d0); end
    checks++;
    if (err_cnt - e0 != 0) begin errors++; $display("FAIL %s error_pulses got %0d want 0", name, err_cnt - e0); end
    checks++;
    if (wr_cnt - w0 != 16) begin errors++; $display("FAIL %s writes got %0d want 16", name, wr_cnt - w0); end
    checks++;
    if (rd_cnt - r0 != 64) begin errors++; $display("FAIL %s reads got %0d want 64", name, rd_cnt - r0); end
    checks++;
    if (load_cnt - l0 != 8) begin errors++; $display("FAIL %s loads got %0d want 8", name, load_cnt - l0); end
    checks++;
    if (clash_cnt - k0 != 0) begin errors++; $display("FAIL %s strobe_overlap got %0d want 0", name, clash_cnt - k0); end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e = exp_c(r, c);
        checks++;
        if (cmem[CB + r * 4 + c] !== e || cstamp[CB + r * 4 + c] < t0) begin
          errors++;
          $display("FAIL %s C[%0d][%0d] got %0d (stamp %0d) want %0d (stamp>=%0d)",
                   name, r, c, cmem[CB + r * 4 + c], cstamp[CB + r * 4 + c], e, t0);
        end
      end
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 1'b0; hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, rd_en, wr_en, sa_load, sa_start} !== 7'd0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000000", {busy, done, error, rd_en, wr_en, sa_load, sa_start});
    end
    checks++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL reset_bus rd_addr=%0d wr_addr=%0d wr_data=%0d want 0", rd_addr, wr_addr, wr_data);
    end
    checks++;
    if ({sa_block_a1, sa_block_a2, sa_block_a3, sa_block_a4,
         sa_block_b1, sa_block_b2, sa_block_b3, sa_block_b4} !== '0) begin
      errors++; $display("FAIL reset_block_regs got nonzero want 0");
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL idle_without_go busy=%b rd_en=%b want 0", busy, rd_en); end
  endtask

  task automatic test_small();
    clear_mats();
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
    run_and_check("small", 1'b0);
    checks++;
    if ({cmem[CB], cmem[CB + 1], cmem[CB + 4], cmem[CB + 5]} !== {16'd19, 16'd22, 16'd43, 16'd50}) begin
      errors++;
      $display("FAIL small_tile got %0d %0d %0d %0d want 19 22 43 50", cmem[CB], cmem[CB + 1], cmem[CB + 4], cmem[CB + 5]);
    end
  endtask

  task automatic test_ones();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = 1;
        bm[r][c] = 1;
      end
    run_and_check("ones", 1'b0);
  endtask

  task automatic test_wrap();
    clear_mats();
    am[0][0] = 200; am[0][2] = 200; bm[0][0] = 200; bm[2][0] = 200;
    run_and_check("wrap", 1'b0);
    checks++;
    if (cmem[CB] !== 16'd14464) begin errors++; $display("FAIL wrap_c00 got %0d want 14464", cmem[CB]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      rand_mats();
      run_and_check("random", 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    rand_mats();
    run_and_check("go_while_busy", 1'b1);
    rand_mats();
    run_and_check("back_to_back", 1'b0);
  endtask

  task automatic test_timeout();
    int e0, w0, s0, d0, n;
    rand_mats();
    put_mats();
    hang = 1'b1;
    e0 = err_cnt; w0 = wr_cnt; s0 = start_cnt; d0 = done_cnt;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL timeout_error_seen got %b want 1", error); end
    checks++;
    if (busy !== 1'b0 || sa_start !== 1'b0) begin errors++; $display("FAIL timeout_abort busy=%b sa_start=%b want 0", busy, sa_start); end
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %b want 0", error); end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 31) begin errors++; $display("FAIL timeout_run_cycles got %0d want 31", start_cnt - s0); end
    checks++;
    if (err_cnt - e0 != 1 || wr_cnt - w0 != 0 || done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL timeout_counts errors=%0d writes=%0d dones=%0d want 1 0 0", err_cnt - e0, wr_cnt - w0, done_cnt - d0);
    end
    hang = 1'b0;
    run_and_check("restart_after_timeout", 1'b0);
  endtask

  task automatic test_reset_midrun();
    int w0, n;
    rand_mats();
    put_mats();
    w0 = wr_cnt;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (sa_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (sa_start !== 1'b1) begin errors++; $display("FAIL midrun_reach_run got %b want 1", sa_start); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sa_start, rd_en, wr_en, busy} !== 4'b0000) begin
      errors++; $display("FAIL midrun_reset_outputs got %b want 0000", {sa_start, rd_en, wr_en, busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt != w0) begin errors++; $display("FAIL midrun_no_writes got %0d want 0", wr_cnt - w0); end
    rst = 1'b1;
    @(negedge clk);
    run_and_check("after_midrun_reset", 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_small();
    test_ones();
    test_wrap();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
